key_input_ctrl: RTL and testbench
=================================

Name: key_input_ctrl

Overview:
- Front-end stage between the host keyboard interface and the game logic (Ghost_unit, Drawing_priority reset).
- Converts raw 8-bit keycode events into held button levels, a rate-limited fire pulse with auto-repeat, and a 12-bit steering wheel value slewed once per video frame.
- Replaces ad-hoc per-cycle decoding so that game logic sees stable, frame-synchronous controls.

Parameters:
- REPEAT_DELAY, 20, frames a held fire key waits before its first auto-repeat pulse.
- REPEAT_RATE, 6, frames between auto-repeat pulses after REPEAT_DELAY.
- WHEEL_STEP, 32, wheel change per frame while slewing or nudging.
- WHEEL_UNIT, 227, wheel target per digit key (target = digit*WHEEL_UNIT; max 9*227 = 2043).
- WHEEL_MAX, 2043, upper saturation limit of wheel.

Ports:
- clk  in  1  pixel/system clock.
- reset  in  1  synchronous, active-high reset.
- keycode  in  8  bit7 = key held; bits[6:0] = key code.
- v_sync  in  1  VGA vertical sync, active-low pulse; used as the frame tick source.
- keystrobe  out  1  registered copy of keycode[7].
- btn_a  out  1  level, high while "A" (65) is held.
- fire_pulse  out  1  one-cycle pulse for "B" (66), with auto-repeat.
- select  out  1  level, high while INSERT (45) is held; drives game reset.
- start  out  1  level, high while DELETE (46) is held.
- left, up, right, down  out  1 each  levels for codes 37, 38, 39, 40.
- wheel  out  12  steering value, 0..WHEEL_MAX.

Behaviour:
- Clocking and reset: all state is clocked on the clk rising edge. Reset applies synchronously to every output. On reset, all outputs are 0, wheel and wheel target are 0, and the repeat FSM is in IDLE.
- Decode:
  - code = keycode[6:0]; held = keycode[7].
  - Button levels are registered, 1-cycle latency: out <= held && (code == K).
  - Only one key is held at a time, so all other levels are 0.
- Frame tick:
  - v_sync is registered into v_d.
  - frame_tick is a 1-cycle pulse on the falling edge (v_d=1, v_sync=0).
  - Ticks are ignored while reset is high.
- Fire FSM (states IDLE, FIRST, REPEAT), with a frame counter cnt (5 bits minimum, sized from the parameters):
  - IDLE: when B is held, fire_pulse=1 for that cycle; cnt <= 0; go to FIRST.
  - FIRST: cnt increments on frame_tick. When cnt reaches REPEAT_DELAY-1 on a tick, pulse fire; cnt <= 0; go to REPEAT.
  - REPEAT: cnt increments on frame_tick. When cnt reaches REPEAT_RATE-1 on a tick, pulse fire; cnt <= 0.
  - In FIRST or REPEAT, B released (not held, or code ≠ 66) returns to IDLE on the next cycle with no pulse.
  - A code change from B to another key while keycode[7] stays high counts as a release.
  - Re-pressing B after IDLE pulses immediately.
  - fire_pulse is never high on two consecutive cycles.
- Wheel target:
  - Digit key 48..57 held: target <= (code-48)*WHEEL_UNIT. The multiply is 4b×8b, truncated to 12 bits.
  - The target is updated every cycle the digit is held.
- Wheel update on each frame_tick:
  - Slew toward target: if |target - wheel| ≤ WHEEL_STEP, wheel <= target; otherwise wheel moves by ±WHEEL_STEP.
  - left held: wheel and target both decrease by WHEEL_STEP, saturating at 0.
  - right held: wheel and target both increase by WHEEL_STEP, saturating at WHEEL_MAX.
  - left/right nudge takes priority over slew in the same tick.
  - No wrap-around is allowed; compute in 13 bits before saturating.
- Simultaneous events: reset beats everything. A frame_tick in the same cycle as a new digit press uses the new target (the target register is bypassed that cycle).
- Reset mid-repeat: the FSM returns to IDLE. A B key still held after reset deasserts produces an immediate pulse.

Optional Feature:
- WHEEL_SLEW_EN.
- Defined: wheel slews as described above.
- Undefined: on a digit press, wheel <= target in the same cycle the target updates, 1-cycle latency with no frame dependency. Left/right nudge still applies per frame_tick with saturation.

Decomposition:
- Package key_input_pkg holds:
  - key code localparams: KEY_A=65, KEY_B=66, KEY_INS=45, KEY_DEL=46, KEY_LEFT=37, KEY_UP=38, KEY_RIGHT=39, KEY_DOWN=40, KEY_0=48, KEY_9=57;
  - typedef enum fire_state_t {IDLE, FIRST, REPEAT};
  - the 12-bit wheel_t typedef.
- One sub-module, key_repeat, contains the fire FSM plus its counter. Its inputs are clk, reset, held, and frame_tick; its output is pulse.

Test Plan:
- Reset, then keycode=8'hC2 (B held) for 30 frames: pulse at press; next pulse at frame 20; then frames 26 and 32 hit only if still held; exactly 3 pulses in 30 frames with REPEAT_DELAY=20 and REPEAT_RATE=6.
- keycode=8'hB5 ('5') held for 1 cycle, then released: target=1135; wheel steps 0, 32, 64, … and reaches 1135 exactly on tick 36 (35*32=1120, then 1135).
- wheel=2043, right held (8'hA7) for 3 frames: wheel stays 2043. Then left held for 2 frames: wheel=1979.
- keycode=8'hAD (INSERT): select=1 exactly one cycle after, select=0 one cycle after release. All other levels stay 0 throughout.
- B held in REPEAT state, reset pulsed for 1 cycle with B still held: outputs cleared and wheel=0; fire_pulse fires on the first cycle after reset deasserts.
- With WHEEL_SLEW_EN undefined, '9' pressed: wheel=2043 one cycle later, with no frame_tick required.

Source files
------------

// File: rtl/key_input_ctrl_pkg.sv
// Shared key codes, fire FSM state type and wheel type for the key input front end.
package key_input_pkg;

  localparam logic [6:0] KEY_A     = 7'd65;
  localparam logic [6:0] KEY_B     = 7'd66;
  localparam logic [6:0] KEY_INS   = 7'd45;
  localparam logic [6:0] KEY_DEL   = 7'd46;
  localparam logic [6:0] KEY_LEFT  = 7'd37;
  localparam logic [6:0] KEY_UP    = 7'd38;
  localparam logic [6:0] KEY_RIGHT = 7'd39;
  localparam logic [6:0] KEY_DOWN  = 7'd40;
  localparam logic [6:0] KEY_0     = 7'd48;
  localparam logic [6:0] KEY_9     = 7'd57;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } fire_state_t;

  typedef logic [11:0] wheel_t;

  // Frame counter must hold the larger of the two terminal counts; never narrower than 5 bits.
  function automatic int cnt_width(input int delay, input int rate);
    int m;
    m = (delay > rate) ? delay : rate;
    return ($clog2(m) > 5) ? $clog2(m) : 5;
  endfunction

endpackage

// File: rtl/key_input_ctrl_if.sv
// Keyboard/frame inputs and decoded control outputs between host interface and game logic.
interface key_input_ctrl_if;
  import key_input_pkg::*;

  logic [7:0] keycode;
  logic       v_sync;
  logic       keystrobe;
  logic       btn_a;
  logic       fire_pulse;
  logic       select;
  logic       start;
  logic       left;
  logic       up;
  logic       right;
  logic       down;
  wheel_t     wheel;

  modport master (
    output keycode, v_sync,
    input  keystrobe, btn_a, fire_pulse, select, start, left, up, right, down, wheel
  );

  modport slave (
    input  keycode, v_sync,
    output keystrobe, btn_a, fire_pulse, select, start, left, up, right, down, wheel
  );

endinterface

// File: rtl/key_input_ctrl_repeat.sv
// Fire key auto-repeat: immediate pulse on press, then one after REPEAT_DELAY frames,
// then one every REPEAT_RATE frames while the key stays held.
//
// state  | meaning
// IDLE   | key not held; a press pulses immediately
// FIRST  | counting frames toward the first auto-repeat
// REPEAT | counting frames between subsequent auto-repeats
module key_repeat
  import key_input_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic held,
  input  logic frame_tick,
  output logic pulse
);

  localparam int CNT_W = cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

  fire_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (held) begin
          state_nxt = FIRST;
          cnt_nxt   = '0;
        end
      end
      FIRST: begin
        if (!held) begin
          state_nxt = IDLE;
        end else if (frame_tick) begin
          if (cnt == DELAY_TC) begin
            state_nxt = REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!held) begin
          state_nxt = IDLE;
        end else if (frame_tick) begin
          if (cnt == RATE_TC) cnt_nxt = '0;
          else                cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pulse_nxt = 1'b0;
    case (state)
      IDLE:    pulse_nxt = held;
      FIRST:   pulse_nxt = held && frame_tick && (cnt == DELAY_TC);
      REPEAT:  pulse_nxt = held && frame_tick && (cnt == RATE_TC);
      default: pulse_nxt = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_input_ctrl.sv
// Keycode front end: held button levels, auto-repeating fire pulse and a frame-stepped wheel.
// Build option WHEEL_SLEW_EN: wheel slews toward the digit target per frame; otherwise it jumps.
module key_input_ctrl
  import key_input_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6,
  parameter int WHEEL_STEP   = 32,
  parameter int WHEEL_UNIT   = 227,
  parameter int WHEEL_MAX    = 2043
) (
  input logic             clk,
  input logic             reset,
  key_input_ctrl_if.slave bus
);

  logic [6:0] code;
  logic       key_held;
  logic       hit_a, hit_b, hit_ins, hit_del, hit_left, hit_up, hit_right, hit_down, hit_digit;

  assign code      = bus.keycode[6:0];
  assign key_held  = bus.keycode[7];
  assign hit_a     = key_held && (code == KEY_A);
  assign hit_b     = key_held && (code == KEY_B);
  assign hit_ins   = key_held && (code == KEY_INS);
  assign hit_del   = key_held && (code == KEY_DEL);
  assign hit_left  = key_held && (code == KEY_LEFT);
  assign hit_up    = key_held && (code == KEY_UP);
  assign hit_right = key_held && (code == KEY_RIGHT);
  assign hit_down  = key_held && (code == KEY_DOWN);
  assign hit_digit = key_held && (code >= KEY_0) && (code <= KEY_9);

  logic v_d, frame_tick;

  always_ff @(posedge clk) begin
    if (reset) v_d <= 1'b0;
    else       v_d <= bus.v_sync;
  end

  assign frame_tick = v_d && !bus.v_sync && !reset;

  logic keystrobe_q, btn_a_q, select_q, start_q, left_q, up_q, right_q, down_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      keystrobe_q <= 1'b0;
      btn_a_q     <= 1'b0;
      select_q    <= 1'b0;
      start_q     <= 1'b0;
      left_q      <= 1'b0;
      up_q        <= 1'b0;
      right_q     <= 1'b0;
      down_q      <= 1'b0;
    end else begin
      keystrobe_q <= key_held;
      btn_a_q     <= hit_a;
      select_q    <= hit_ins;
      start_q     <= hit_del;
      left_q      <= hit_left;
      up_q        <= hit_up;
      right_q     <= hit_right;
      down_q      <= hit_down;
    end
  end

  logic fire_pulse;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat (
    .clk        (clk),
    .reset      (reset),
    .held       (hit_b),
    .frame_tick (frame_tick),
    .pulse      (fire_pulse)
  );

  // Nudges are computed one bit wider so an underflow shows up as bit 12 rather than a wrap.
  function automatic wheel_t sat_dec(input wheel_t v);
    logic [12:0] s;
    s = {1'b0, v} - 13'(WHEEL_STEP);
    return s[12] ? '0 : s[11:0];
  endfunction

  function automatic wheel_t sat_inc(input wheel_t v);
    logic [12:0] s;
    s = {1'b0, v} + 13'(WHEEL_STEP);
    return (s > 13'(WHEEL_MAX)) ? wheel_t'(WHEEL_MAX) : s[11:0];
  endfunction

`ifdef WHEEL_SLEW_EN
  function automatic wheel_t slew(input wheel_t w, input wheel_t t);
    if (t >= w) return ((t - w) <= wheel_t'(WHEEL_STEP)) ? t : w + wheel_t'(WHEEL_STEP);
    else        return ((w - t) <= wheel_t'(WHEEL_STEP)) ? t : w - wheel_t'(WHEEL_STEP);
  endfunction
`endif

  logic [3:0] digit;
  wheel_t     tgt_q, tgt_dig, tgt_eff, tgt_nxt;
  wheel_t     wheel_q, wheel_nxt;

  assign digit   = 4'(code - KEY_0);
  assign tgt_dig = 12'(digit) * 12'(WHEEL_UNIT);
  // A digit pressed on a tick must steer toward the new target, not last cycle's.
  assign tgt_eff = hit_digit ? tgt_dig : tgt_q;

  always_comb begin
    tgt_nxt   = tgt_eff;
    wheel_nxt = wheel_q;
`ifndef WHEEL_SLEW_EN
    if (hit_digit) wheel_nxt = tgt_dig;
`endif
    if (frame_tick) begin
      if (hit_left) begin
        wheel_nxt = sat_dec(wheel_q);
        tgt_nxt   = sat_dec(tgt_eff);
      end else if (hit_right) begin
        wheel_nxt = sat_inc(wheel_q);
        tgt_nxt   = sat_inc(tgt_eff);
      end
`ifdef WHEEL_SLEW_EN
      else begin
        wheel_nxt = slew(wheel_q, tgt_eff);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q   <= '0;
      wheel_q <= '0;
    end else begin
      tgt_q   <= tgt_nxt;
      wheel_q <= wheel_nxt;
    end
  end

  assign bus.keystrobe  = keystrobe_q;
  assign bus.btn_a      = btn_a_q;
  assign bus.fire_pulse = fire_pulse;
  assign bus.select     = select_q;
  assign bus.start      = start_q;
  assign bus.left       = left_q;
  assign bus.up         = up_q;
  assign bus.right      = right_q;
  assign bus.down       = down_q;
  assign bus.wheel      = wheel_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Self-checking bench for key_input_ctrl against a frame/hold-count reference model.
module tb_key_input_ctrl;

  localparam int RD = 20;
  localparam int RR = 6;
  localparam int WS = 32;
  localparam int WU = 227;
  localparam int WM = 2043;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  key_input_ctrl_if bus ();

  key_input_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected outputs after the most recent clock edge.
  bit e_ks, e_a, e_fire, e_sel, e_start, e_l, e_u, e_r, e_d;
  int e_wheel, m_tgt, b_ticks;
  bit in_hold, m_vprev;

  int codes[16] = '{65, 66, 45, 46, 37, 38, 39, 40, 48, 50, 53, 57, 66, 37, 39, 12};

  function automatic logic [20:0] obs_vec();
    return {bus.keystrobe, bus.btn_a, bus.fire_pulse, bus.select, bus.start,
            bus.left, bus.up, bus.right, bus.down, bus.wheel};
  endfunction

  function automatic logic [20:0] exp_vec();
    return {e_ks, e_a, e_fire, e_sel, e_start, e_l, e_u, e_r, e_d, 12'(e_wheel)};
  endfunction

  task automatic model_step(input logic [7:0] kc, input logic vs, input logic rst);
    int  code;
    bit  held, tick, b_now;
    code = int'(kc[6:0]);
    held = kc[7];
    tick = m_vprev && !vs && !rst;
    m_vprev = rst ? 1'b0 : vs;
    if (rst) begin
      {e_ks, e_a, e_fire, e_sel, e_start, e_l, e_u, e_r, e_d} = '0;
      e_wheel = 0; m_tgt = 0; in_hold = 0; b_ticks = 0;
    end else begin
      e_ks = held;          e_a  = held && code == 65;
      e_sel = held && code == 45; e_start = held && code == 46;
      e_l = held && code == 37;  e_u = held && code == 38;
      e_r = held && code == 39;  e_d = held && code == 40;
      b_now  = held && code == 66;
      e_fire = 0;
      if (!b_now) in_hold = 0;
      else if (!in_hold) begin
        in_hold = 1; b_ticks = 0; e_fire = 1;
      end else if (tick) begin
        b_ticks++;
        if (b_ticks == RD || (b_ticks > RD && (b_ticks - RD) % RR == 0)) e_fire = 1;
      end
      if (held && code >= 48 && code <= 57) begin
        m_tgt = (code - 48) * WU;
`ifndef WHEEL_SLEW_EN
        e_wheel = m_tgt;
`endif
      end
      if (tick) begin
        if (e_l) begin
          e_wheel = (e_wheel - WS < 0) ? 0 : e_wheel - WS;
          m_tgt   = (m_tgt - WS < 0) ? 0 : m_tgt - WS;
        end else if (e_r) begin
          e_wheel = (e_wheel + WS > WM) ? WM : e_wheel + WS;
          m_tgt   = (m_tgt + WS > WM) ? WM : m_tgt + WS;
        end
`ifdef WHEEL_SLEW_EN
        else begin
          if (m_tgt - e_wheel <= WS && e_wheel - m_tgt <= WS) e_wheel = m_tgt;
          else if (m_tgt > e_wheel) e_wheel = e_wheel + WS;
          else e_wheel = e_wheel - WS;
        end
`endif
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the edge's effect visible.
  task automatic step(input logic [7:0] kc, input logic vs, input logic rst);
    bus.keycode = kc;
    bus.v_sync  = vs;
    reset       = rst;
    model_step(kc, vs, rst);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(8'($urandom), 1'b1, 1'b1);
    n_tests++;
    if (obs_vec() !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    step(8'h00, 1'b1, 1'b0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_levels();
    int lv[7] = '{65, 45, 46, 37, 38, 39, 40};
    step(8'h2D, 1'b1, 1'b0);
    n_tests++;
    if (bus.select !== 1'b0) begin n_fail++; $display("FAIL ins_before: got %b want 0", bus.select); end
    for (int i = 0; i < 3; i++) begin
      step(8'hAD, 1'b1, 1'b0);
      n_tests++;
      if (bus.select !== 1'b1) begin n_fail++; $display("FAIL ins_held: got %b want 1", bus.select); end
      n_tests++;
      if ({bus.btn_a, bus.fire_pulse, bus.start, bus.left, bus.up, bus.right, bus.down} !== 7'd0) begin
        n_fail++;
        $display("FAIL ins_others: got %b want 0",
                 {bus.btn_a, bus.fire_pulse, bus.start, bus.left, bus.up, bus.right, bus.down});
      end
    end
    step(8'h2D, 1'b1, 1'b0);
    n_tests++;
    if (bus.select !== 1'b0) begin n_fail++; $display("FAIL ins_release: got %b want 0", bus.select); end
    foreach (lv[i]) begin
      step({1'b1, 7'(lv[i])}, 1'b1, 1'b0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL level_press %0d: got %h want %h", lv[i], obs_vec(), exp_vec());
      end
      step({1'b0, 7'(lv[i])}, 1'b1, 1'b0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL level_release %0d: got %h want %h", lv[i], obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_fire();
    int   pulses = 0, first_rep = -1, consec = 0;
    logic prev;
    step(8'h00, 1'b1, 1'b1);
    step(8'hC2, 1'b1, 1'b0);
    n_tests++;
    if (bus.fire_pulse !== 1'b1) begin n_fail++; $display("FAIL fire_press: got %b want 1", bus.fire_pulse); end
    pulses = int'(bus.fire_pulse);
    prev   = bus.fire_pulse;
    for (int f = 1; f <= 30; f++) begin
      for (int c = 0; c < 8; c++) begin
        step(8'hC2, c >= 2, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL fire_frame %0d.%0d: got %h want %h", f, c, obs_vec(), exp_vec());
        end
        if (bus.fire_pulse === 1'b1) begin
          pulses++;
          if (first_rep < 0) first_rep = f;
          if (prev === 1'b1) consec++;
        end
        prev = bus.fire_pulse;
      end
    end
    n_tests++;
    if (pulses !== 3) begin n_fail++; $display("FAIL fire_count: got %0d want 3", pulses); end
    n_tests++;
    if (first_rep !== RD) begin n_fail++; $display("FAIL fire_first_repeat: got %0d want %0d", first_rep, RD); end
    n_tests++;
    if (consec !== 0) begin n_fail++; $display("FAIL fire_consecutive: got %0d want 0", consec); end
    step(8'hC1, 1'b1, 1'b0);
    n_tests++;
    if (bus.fire_pulse !== 1'b0) begin n_fail++; $display("FAIL fire_code_change: got %b want 0", bus.fire_pulse); end
    step(8'hC2, 1'b1, 1'b0);
    n_tests++;
    if (bus.fire_pulse !== 1'b1) begin n_fail++; $display("FAIL fire_repress: got %b want 1", bus.fire_pulse); end
    step(8'h42, 1'b1, 1'b0);
  endtask

  task automatic test_wheel_slew();
    step(8'h00, 1'b1, 1'b1);
    step(8'hB5, 1'b1, 1'b0);
`ifdef WHEEL_SLEW_EN
    n_tests++;
    if (bus.wheel !== 12'd0) begin n_fail++; $display("FAIL slew_press: got %0d want 0", bus.wheel); end
    for (int f = 1; f <= 36; f++) begin
      for (int c = 0; c < 8; c++) begin
        step(8'h35, c >= 2, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL slew_frame %0d.%0d: got %h want %h", f, c, obs_vec(), exp_vec());
        end
      end
      if (f == 1 || f == 35) begin
        n_tests++;
        if (bus.wheel !== 12'(32 * f)) begin
          n_fail++; $display("FAIL slew_tick %0d: got %0d want %0d", f, bus.wheel, 32 * f);
        end
      end
    end
    n_tests++;
    if (bus.wheel !== 12'd1135) begin n_fail++; $display("FAIL slew_final: got %0d want 1135", bus.wheel); end
`else
    n_tests++;
    if (bus.wheel !== 12'd1135) begin n_fail++; $display("FAIL jump_press: got %0d want 1135", bus.wheel); end
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 8; c++) step(8'h35, c >= 2, 1'b0);
    n_tests++;
    if (bus.wheel !== 12'd1135) begin n_fail++; $display("FAIL jump_hold: got %0d want 1135", bus.wheel); end
`endif
  endtask

  task automatic test_wheel_sat();
    step(8'h00, 1'b1, 1'b1);
    step(8'hB9, 1'b1, 1'b0);
`ifdef WHEEL_SLEW_EN
    for (int f = 0; f < 64; f++)
      for (int c = 0; c < 8; c++) step(8'h39, c >= 2, 1'b0);
`endif
    n_tests++;
    if (bus.wheel !== 12'd2043) begin n_fail++; $display("FAIL sat_reach: got %0d want 2043", bus.wheel); end
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 8; c++) step(8'hA7, c >= 2, 1'b0);
      n_tests++;
      if (bus.wheel !== 12'd2043) begin n_fail++; $display("FAIL sat_right %0d: got %0d want 2043", f, bus.wheel); end
    end
    for (int f = 1; f <= 2; f++) begin
      for (int c = 0; c < 8; c++) step(8'hA5, c >= 2, 1'b0);
      n_tests++;
      if (bus.wheel !== 12'(2043 - 32 * f)) begin
        n_fail++; $display("FAIL sat_left %0d: got %0d want %0d", f, bus.wheel, 2043 - 32 * f);
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL sat_model %0d: got %h want %h", f, obs_vec(), exp_vec());
      end
    end
    step(8'h25, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_repeat();
    step(8'h00, 1'b1, 1'b1);
    step(8'hB9, 1'b1, 1'b0);
    step(8'hC2, 1'b1, 1'b0);
    for (int f = 0; f < 22; f++)
      for (int c = 0; c < 8; c++) step(8'hC2, c >= 2, 1'b0);
    n_tests++;
    if (bus.wheel === 12'd0) begin n_fail++; $display("FAIL mid_wheel_nonzero: got %0d want nonzero", bus.wheel); end
    step(8'hC2, 1'b1, 1'b1);
    n_tests++;
    if (obs_vec() !== 21'd0) begin n_fail++; $display("FAIL mid_reset_clear: got %h want 0", obs_vec()); end
    step(8'hC2, 1'b1, 1'b0);
    n_tests++;
    if (bus.fire_pulse !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pulse: got %b want 1", bus.fire_pulse); end
    step(8'hC2, 1'b1, 1'b0);
    n_tests++;
    if (bus.fire_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_reset_single: got %b want 0", bus.fire_pulse); end
    step(8'h42, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int         n = 0;
    int         dur;
    logic [7:0] kc;
    while (n < 3000) begin
      kc  = {($urandom_range(0, 3) != 0), 7'(codes[$urandom_range(0, 15)])};
      dur = (kc[6:0] == 7'd66) ? int'($urandom_range(1, 160)) : int'($urandom_range(1, 12));
      for (int i = 0; i < dur; i++) begin
        step(kc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        n++;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL random cycle %0d: got %h want %h", n, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    bus.keycode = 8'h00;
    bus.v_sync  = 1'b1;
    reset       = 1'b1;
    m_vprev     = 1'b0;
    @(negedge clk);
    test_reset();
    test_levels();
    test_fire();
    test_wheel_slew();
    test_wheel_sat();
    test_reset_mid_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule
